// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA timing generator with registered,
//                blank-aware colour output stage and line/frame strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CNT_W    = 10,
    parameter int PIX_DIV  = 4,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blank,
    input  logic [2:0]       red_in,
    input  logic [2:0]       green_in,
    input  logic [1:0]       blue_in,
    output logic [2:0]       red,
    output logic [2:0]       green,
    output logic [1:0]       blue,
    output logic [CNT_W-1:0] hPix,
    output logic [CNT_W-1:0] vPix,
    output logic [CNT_W-1:0] HC,
    output logic [CNT_W-1:0] VC,
    output logic             pix,
    output logic             HS,
    output logic             VS,
    output logic             active,
    output logic             line_start,
    output logic             frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0]   c_H_LAST   = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0]   c_V_LAST   = CNT_W'(c_V_TOTAL - 1);

    // One extra bit so boundaries equal to the total never overflow
    localparam logic [CNT_W:0] c_H_ACT  = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] c_V_ACT  = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] c_HS_BEG = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] c_HS_END = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] c_VS_BEG = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] c_VS_END = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_DIV_W-1:0] w_div_nxt;
    logic               r_pix;
    logic [CNT_W-1:0]   r_hc;
    logic [CNT_W-1:0]   r_vc;
    logic [CNT_W:0]     w_hc_x;
    logic [CNT_W:0]     w_vc_x;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_in_active;
    logic               w_in_hsync;
    logic               w_in_vsync;
    logic [2:0]         r_red;
    logic [2:0]         r_green;
    logic [1:0]         r_blue;
    logic               r_active;
    logic               r_hs;
    logic               r_vs;

    assign w_div_nxt   = (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + 1'b1;
    assign w_hc_x      = {1'b0, r_hc};
    assign w_vc_x      = {1'b0, r_vc};
    assign w_h_last    = (r_hc == c_H_LAST);
    assign w_v_last    = (r_vc == c_V_LAST);
    assign w_in_active = (w_hc_x < c_H_ACT) && (w_vc_x < c_V_ACT);
    assign w_in_hsync  = (w_hc_x >= c_HS_BEG) && (w_hc_x < c_HS_END);
    assign w_in_vsync  = (w_vc_x >= c_VS_BEG) && (w_vc_x < c_VS_END);

    // pix is registered from the next divider value so it lines up with div_cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_pix     <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_pix     <= (w_div_nxt == c_DIV_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (r_pix) begin
            if (w_h_last) begin
                r_hc <= '0;
                r_vc <= w_v_last ? '0 : r_vc + 1'b1;
            end else begin
                r_hc <= r_hc + 1'b1;
            end
        end
    end

    // Output stage samples the pre-increment coordinate, so it trails it by one pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_red    <= '0;
            r_green  <= '0;
            r_blue   <= '0;
            r_active <= 1'b0;
            r_hs     <= ~HS_POL;
            r_vs     <= ~VS_POL;
        end else if (r_pix) begin
            r_red    <= (w_in_active && !blank) ? red_in   : 3'd0;
            r_green  <= (w_in_active && !blank) ? green_in : 3'd0;
            r_blue   <= (w_in_active && !blank) ? blue_in  : 2'd0;
            r_active <= w_in_active;
            r_hs     <= w_in_hsync ? HS_POL : ~HS_POL;
            r_vs     <= w_in_vsync ? VS_POL : ~VS_POL;
        end
    end

    assign hPix        = w_in_active ? r_hc : '0;
    assign vPix        = w_in_active ? r_vc : '0;
    assign HC          = r_hc;
    assign VC          = r_vc;
    assign pix         = r_pix;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign active      = r_active;
    assign HS          = r_hs;
    assign VS          = r_vs;
    assign line_start  = r_pix && w_h_last;
    assign frame_start = r_pix && w_h_last && w_v_last;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Directed bench: scaled main instance (PIX_DIV=4) and a tiny
//                instance (PIX_DIV=1, HS_POL=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    // Main instance geometry: H 16/4/6/4 = 30, V 12/2/2/3 = 19, 4 clks/pixel
    localparam int c_FRAME_CLKS = 30 * 19 * 4;
    localparam int c_LINE_CLKS  = 30 * 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic blank = 1'b0;

    logic [2:0] m_red_in, m_green_in, m_red, m_green;
    logic [1:0] m_blue_in, m_blue;
    logic [9:0] m_hPix, m_vPix, m_HC, m_VC;
    logic       m_pix, m_HS, m_VS, m_active, m_line_start, m_frame_start;

    logic [2:0] s_red, s_green;
    logic [1:0] s_blue;
    logic [9:0] s_hPix, s_vPix, s_HC, s_VC;
    logic       s_pix, s_HS, s_VS, s_active, s_line_start, s_frame_start;

    // Pixel source for the main instance
    assign m_red_in   = m_hPix[2:0];
    assign m_green_in = m_vPix[2:0];
    assign m_blue_in  = 2'b11;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CNT_W(10), .PIX_DIV(4), .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_main (
        .clk(clk), .rst(rst), .blank(blank),
        .red_in(m_red_in), .green_in(m_green_in), .blue_in(m_blue_in),
        .red(m_red), .green(m_green), .blue(m_blue),
        .hPix(m_hPix), .vPix(m_vPix), .HC(m_HC), .VC(m_VC),
        .pix(m_pix), .HS(m_HS), .VS(m_VS), .active(m_active),
        .line_start(m_line_start), .frame_start(m_frame_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CNT_W(10), .PIX_DIV(1), .HS_POL(1'b1), .VS_POL(1'b0)
    ) u_small (
        .clk(clk), .rst(rst), .blank(1'b0),
        .red_in(3'b101), .green_in(3'b010), .blue_in(2'b01),
        .red(s_red), .green(s_green), .blue(s_blue),
        .hPix(s_hPix), .vPix(s_vPix), .HC(s_HC), .VC(s_VC),
        .pix(s_pix), .HS(s_HS), .VS(s_VS), .active(s_active),
        .line_start(s_line_start), .frame_start(s_frame_start)
    );

    typedef struct {
        logic [9:0] hc;
        logic [9:0] vc;
        logic       blk;
        logic [2:0] er;
        logic [2:0] eg;
        logic [1:0] eb;
        logic       ea;
        logic       ehs;
        logic       evs;
    } vec_t;

    vec_t vecs [14];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for the pix clk of coordinate (h,v) on the main instance
    task automatic goto_m(input logic [9:0] h, input logic [9:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(negedge clk);
            if (m_pix && m_HC == h && m_VC == v) ok = 1'b1;
        end
        if (!ok) check($sformatf("goto (%0d,%0d) timeout", h, v), 32'd0, 32'd1);
    endtask

    initial begin
        bit ok;
        int n, gap, bad, line_at, hs_low, vs_low, hmax, vmax;
        logic [9:0] prev;

        //            hc     vc   blk  r     g     b     act   hs    vs
        vecs[0]  = '{10'd0,  10'd0,  0, 3'd0, 3'd0, 2'd3, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{10'd7,  10'd4,  0, 3'd7, 3'd4, 2'd3, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{10'd8,  10'd4,  1, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{10'd9,  10'd4,  0, 3'd1, 3'd4, 2'd3, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{10'd5,  10'd7,  0, 3'd5, 3'd7, 2'd3, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{10'd16, 10'd7,  0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{10'd19, 10'd7,  0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{10'd20, 10'd7,  0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{10'd25, 10'd7,  0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{10'd26, 10'd7,  0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{10'd15, 10'd11, 0, 3'd7, 3'd3, 2'd3, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{10'd3,  10'd14, 0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{10'd21, 10'd15, 0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{10'd3,  10'd16, 0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst HC/VC", {m_HC, m_VC}, 20'd0);
        check("rst pix/strobes", {m_pix, m_line_start, m_frame_start, m_active}, 4'b0000);
        check("rst colour", {m_red, m_green, m_blue}, 8'd0);
        check("rst HS/VS", {m_HS, m_VS}, 2'b11);
        check("small rst HS/VS/pix", {s_HS, s_VS, s_pix}, 3'b010);

        // Divider: first tick PIX_DIV-1 clks after release, then every PIX_DIV
        @(negedge clk) rst = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!m_pix && n < 20);
        check("first pix latency", n, 3);
        check("first tick at HC=0", {m_HC, m_VC}, 20'd0);
        @(posedge clk); #1;
        check("pix one clk wide", m_pix, 1'b0);
        gap = 1;
        while (!m_pix && gap < 20) begin @(posedge clk); #1; gap++; end
        check("pix period", gap, 4);

        // Table-driven colour/sync vectors
        for (int i = 0; i < 14; i++) begin
            goto_m(vecs[i].hc, vecs[i].vc, ok);
            if (ok) begin
                check($sformatf("vec%0d hPix/vPix", i), {m_hPix, m_vPix},
                      vecs[i].ea ? {vecs[i].hc, vecs[i].vc} : 20'd0);
                blank = vecs[i].blk;
                @(posedge clk); #1;
                blank = 1'b0;
                check($sformatf("vec%0d outputs", i),
                      {m_red, m_green, m_blue, m_active, m_HS, m_VS},
                      {vecs[i].er, vecs[i].eg, vecs[i].eb, vecs[i].ea, vecs[i].ehs, vecs[i].evs});
            end
        end

        // Frame and line periods, sync widths
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!m_frame_start && n < 3000);
        check("frame_start on last tick", {m_pix, m_HC, m_VC}, {1'b1, 10'd29, 10'd18});
        n = 0; line_at = 0; hs_low = 0; vs_low = 0;
        do begin
            @(posedge clk); #1; n++;
            if (n <= c_LINE_CLKS && !m_HS) hs_low++;
            if (!m_VS) vs_low++;
            if (m_line_start && line_at == 0) line_at = n;
        end while (!m_frame_start && n < 3000);
        check("frame period clks", n, c_FRAME_CLKS);
        check("line period clks", line_at, c_LINE_CLKS);
        check("HS low clks", hs_low, 6 * 4);
        check("VS low clks", vs_low, 2 * c_LINE_CLKS);

        // Reset mid-frame
        goto_m(10'd10, 10'd8, ok);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("midrst counters", {m_HC, m_VC}, 20'd0);
            check("midrst syncs/colour", {m_HS, m_VS, m_red, m_green, m_blue, m_active},
                  {2'b11, 8'd0, 1'b0});
        end
        @(negedge clk) rst = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!m_frame_start && n < 5000);
        // First tick lands 3 clks after release; frame_start is that frame's last tick
        check("frame after midrst", n, c_FRAME_CLKS - 1);

        // Small instance
        bad = 0;
        for (int i = 0; i < 16; i++) begin @(posedge clk); #1; if (s_pix !== 1'b1) bad++; end
        check("small pix constant", bad, 0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!s_frame_start && n < 100);
        check("small frame_start at wrap", {s_HC, s_VC}, {10'd7, 10'd5});
        prev = s_HC; n = 0; bad = 0; hmax = 0; vmax = 0;
        do begin
            @(posedge clk); #1; n++;
            if (s_HS !== (prev == 10'd5 || prev == 10'd6)) bad++;
            prev = s_HC;
            if (int'(s_HC) > hmax) hmax = int'(s_HC);
            if (int'(s_VC) > vmax) vmax = int'(s_VC);
        end while (!s_frame_start && n < 200);
        check("small frame period", n, 48);
        check("small HS at HC 5,6", bad, 0);
        check("small HC/VC max", {hmax[15:0], vmax[15:0]}, {16'd7, 16'd5});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
